// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for the CPU load/store port. One request at a time is
//   accepted over req_valid/req_ready. The request then waits WAIT_CYCLES states
//   before committing to a byte-addressed little-endian RAM, and the result is
//   returned over rsp_valid/rsp_ready.
//   Build option: define MEM_ERR_EN to add rsp_err. With it, a misaligned word
//   access skips the RAM and reports an error. Without it, a misaligned word
//   access is silently aligned down.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_we, req_byte         1 = store / 1 = byte access
//   req_addr, req_wdata      byte address (upper bits alias), store data
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata                load data (0 for stores)
//   rsp_err                  (MEM_ERR_EN only) misaligned word access
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 17,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata
`ifdef MEM_ERR_EN
  ,
  output logic        rsp_err
`endif
);

  localparam int         DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WC    = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COMMIT, S_RESP} state_t;

  state_t                  state, nxt;
  logic [3:0]              cnt;
  logic                    cap_we, cap_byte;
  logic [ADDR_WIDTH-1:0]   cap_addr, wa;
  logic [31:0]             cap_wdata, rd_word, commit_data;
  logic [7:0]              rd_byte;
  logic                    acc_err;
  logic [7:0]              mem [0:DEPTH-1];

  // Address bits above ADDR_WIDTH alias by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH];

  assign req_ready = (state == S_IDLE) && !rst;
  assign rsp_valid = (state == S_RESP);

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (req_valid) nxt = (WC == 4'd0) ? S_COMMIT : S_WAIT;
      S_WAIT:   if (cnt <= 4'd1) nxt = S_COMMIT;
      S_COMMIT: nxt = S_RESP;
      S_RESP:   if (rsp_ready) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  assign wa      = {cap_addr[ADDR_WIDTH-1:2], 2'b00};
  assign rd_word = {mem[{wa[ADDR_WIDTH-1:2], 2'b11}], mem[{wa[ADDR_WIDTH-1:2], 2'b10}],
                    mem[{wa[ADDR_WIDTH-1:2], 2'b01}], mem[wa]};
  assign rd_byte = mem[cap_addr];

`ifdef MEM_ERR_EN
  assign acc_err = !cap_byte && (cap_addr[1:0] != 2'b00);
`else
  assign acc_err = 1'b0;
`endif

  always_comb begin
    commit_data = 32'h0;
    if (!cap_we && !acc_err)
      commit_data = cap_byte ? {24'h0, rd_byte} : rd_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      rsp_rdata <= 32'h0;
`ifdef MEM_ERR_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      state <= nxt;
      if (state == S_IDLE && req_valid) begin
        cap_we    <= req_we;
        cap_byte  <= req_byte;
        cap_addr  <= req_addr[ADDR_WIDTH-1:0];
        cap_wdata <= req_wdata;
        cnt       <= WC;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (state == S_COMMIT) begin
        rsp_rdata <= commit_data;
`ifdef MEM_ERR_EN
        rsp_err   <= acc_err;
`endif
      end
    end
  end

  // RAM contents survive reset; the write is suppressed if reset lands on COMMIT.
  always_ff @(posedge clk) begin
    if (state == S_COMMIT && cap_we && !acc_err && !rst) begin
      if (cap_byte) begin
        mem[cap_addr] <= cap_wdata[7:0];
      end else begin
        mem[wa]                              <= cap_wdata[7:0];
        mem[{wa[ADDR_WIDTH-1:2], 2'b01}]     <= cap_wdata[15:8];
        mem[{wa[ADDR_WIDTH-1:2], 2'b10}]     <= cap_wdata[23:16];
        mem[{wa[ADDR_WIDTH-1:2], 2'b11}]     <= cap_wdata[31:24];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  localparam int AW = 17;
  localparam int W  = 2;

  logic        clk = 0, rst = 1;
  logic        req_valid = 0, req_ready, req_we = 0, req_byte = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        rsp_valid, rsp_ready = 0;
  logic [31:0] rsp_rdata;
`ifdef MEM_ERR_EN
  logic        rsp_err;
`endif

  int n_assert = 0, n_fail = 0;
  logic [7:0] mdl [logic [AW-1:0]];

  data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata)
`ifdef MEM_ERR_EN
    , .rsp_err(rsp_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference: little-endian byte memory, aliasing on the low AW address bits.
  function automatic logic [31:0] mdl_word(input logic [AW-1:0] a);
    logic [AW-1:0] b;
    b = a & ~AW'(3);
    return {mdl[b + AW'(3)], mdl[b + AW'(2)], mdl[b + AW'(1)], mdl[b]};
  endfunction

  function automatic logic mdl_err(input logic byt, input logic [31:0] addr);
`ifdef MEM_ERR_EN
    return !byt && (addr[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic xact(input string tag, input logic we, input logic byt,
                      input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    logic [AW-1:0] a, b;
    logic [31:0]   exp_rd;
    logic          exp_err;
    int            lat, guard;
    a       = addr[AW-1:0];
    exp_err = mdl_err(byt, addr);
    exp_rd  = 32'h0;
    if (!we && !exp_err) exp_rd = byt ? {24'h0, mdl[a]} : mdl_word(a);
    if (we && !exp_err) begin
      if (byt) mdl[a] = wdata[7:0];
      else begin
        b = a & ~AW'(3);
        for (int i = 0; i < 4; i++) mdl[b + AW'(i)] = wdata[8*i +: 8];
      end
    end

    @(negedge clk);
    req_valid = 1; req_we = we; req_byte = byt; req_addr = addr; req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    check({tag, "/accept_timeout"}, 32'(guard < 50), 32'd1);
    @(posedge clk); #1;
    // Scramble request fields after capture; they must have no effect.
    req_valid = 0; req_we = ~we; req_byte = ~byt; req_addr = $urandom; req_wdata = $urandom;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      if (req_ready !== 1'b0) check({tag, "/busy_ready"}, 32'(req_ready), 32'd0);
      @(posedge clk); #1; lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(W + 1));
    check({tag, "/rdata"}, rsp_rdata, exp_rd);
`ifdef MEM_ERR_EN
    check({tag, "/err"}, 32'(rsp_err), 32'(exp_err));
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "/hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "/hold_rdata"}, rsp_rdata, exp_rd);
      check({tag, "/hold_ready"}, 32'(req_ready), 32'd0);
    end
    @(negedge clk); rsp_ready = 1;
    @(posedge clk); #1;
    check({tag, "/post_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "/post_ready"}, 32'(req_ready), 32'd1);
    rsp_ready = 0;
  endtask

  initial begin
    logic [31:0] addr, d;
    logic        we, byt;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst/req_ready", 32'(req_ready), 32'd0);
    check("rst/rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst/rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    check("idle/req_ready", 32'(req_ready), 32'd1);

    // rsp_ready without rsp_valid is ignored
    rsp_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("idle/stray_rsp_ready", 32'(rsp_valid), 32'd0);
    rsp_ready = 0;

    // Word store/load, byte merge, byte load
    xact("st_w100", 1, 0, 32'h100, 32'hDEADBEEF, 0);
    xact("ld_w100", 0, 0, 32'h100, 32'h0, 0);
    check("t1/value", mdl_word(17'h100), 32'hDEADBEEF);
    xact("st_b101", 1, 1, 32'h101, 32'h555555AA, 0);
    xact("ld_w100b", 0, 0, 32'h100, 32'h0, 0);
    xact("ld_b103", 0, 1, 32'h103, 32'h0, 0);

    // Back-pressure held for 5 cycles
    xact("ld_hold", 0, 0, 32'h100, 32'h0, 5);

    // Alias through upper address bits
    xact("ld_alias", 0, 0, 32'h0002_0100, 32'h0, 0);

    // Reset during WAIT drops the store
    xact("st_w200", 1, 0, 32'h200, 32'hCAFEF00D, 0);
    @(negedge clk);
    req_valid = 1; req_we = 1; req_byte = 0; req_addr = 32'h200; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 0;
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    check("rstwait/rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstwait/req_ready", 32'(req_ready), 32'd0);
    @(negedge clk); rst = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rstwait/rsp_valid_after", 32'(rsp_valid), 32'd0);
    check("rstwait/req_ready_after", 32'(req_ready), 32'd1);
    xact("ld_w200", 0, 0, 32'h200, 32'h0, 0);

    // Misaligned accesses
    xact("ld_w102", 0, 0, 32'h102, 32'h0, 0);
    xact("ld_b102", 0, 1, 32'h102, 32'h0, 0);
    xact("st_w106", 1, 0, 32'h106, 32'h0BADF00D, 0);
    xact("ld_w104", 0, 0, 32'h104, 32'h0, 0);

    // Randomized traffic in a prefilled window, random alias bits
    for (int i = 0; i < 16; i++)
      xact("fill", 1, 0, 32'h300 + 32'(4 * i), $urandom, 0);
    for (int i = 0; i < 40; i++) begin
      addr = {15'($urandom), 17'h300 + 17'($urandom_range(0, 63))};
      we   = 1'($urandom);
      byt  = 1'($urandom);
      d    = $urandom;
      xact("rand", we, byt, addr, d, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
